// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   DEFAULT_WIDTH - default operand/result width
//   state_t       - control FSM state encoding (IDLE, SHIFT, DONE)
//   cnt_width()   - bit-counter width for a given operand width
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    // The max() guards the degenerate case so the vector never collapses to 0 bits.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: x - y - bin.
// Latency: purely combinational, zero cycles.
// Backpressure: none (no state).
//
// Ports:
//   x    - minuend bit
//   y    - subtrahend bit
//   bin  - borrow in
//   d    - difference bit
//   bout - borrow out
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // Borrow when y beats x outright, or when they tie and a borrow is already pending.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: {bout,diff} = a - b - bin, one bit per clock, LSB first.
// Latency: done_valid rises exactly WIDTH edges after the edge that accepts operands.
// Backpressure: start_ready low while busy; result held in DONE until done_ready.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   start_valid/start_ready  - operand handshake (a, b, bin sampled on accept)
//   a, b, bin                - minuend, subtrahend, borrow-in
//   diff, bout               - registered result, retained until the next completion
//   done_valid/done_ready    - result handshake
//   busy                     - high in SHIFT or DONE
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH   // legal range 2..32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             cell_d;
    logic             cell_bout;

    full_subtractor u_cell (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Next-state and output logic.
    // The minuend register doubles as the result shift register: each consumed
    // LSB of a_q is replaced by a difference bit entering at the MSB, so after
    // WIDTH shifts a_q holds the complete difference.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        br_d        = br_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        busy        = 1'b0;

        case (state_q)
            IDLE: begin
                // Gated by rst so the block never advertises ready while held in reset.
                start_ready = ~rst;
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                busy = 1'b1;
                a_d  = {cell_d, a_q[WIDTH-1:1]};
                b_d  = {1'b0,   b_q[WIDTH-1:1]};
                br_d = cell_bout;
                if (cnt_q == LAST_BIT) begin
                    // Counter holds at WIDTH-1 rather than wrapping.
                    diff_d  = {cell_d, a_q[WIDTH-1:1]};
                    bout_d  = cell_bout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DONE: begin
                busy       = 1'b1;
                done_valid = 1'b1;
                if (done_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for the directed
// scenarios and a 4-bit instance for the exhaustive sweep.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_subtractor;

    logic clk;
    logic rst;

    // 8-bit instance
    logic       start_valid, start_ready;
    logic [7:0] a, b, diff;
    logic       bin, bout, done_valid, done_ready, busy;

    // 4-bit instance
    logic       sv4, sr4;
    logic [3:0] a4, b4, diff4;
    logic       bin4, bout4, dv4, dr4, busy4;

    int checks;
    int errors;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .bin         (bin),
        .diff        (diff),
        .bout        (bout),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .busy        (busy)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .start_valid (sv4),
        .start_ready (sr4),
        .a           (a4),
        .b           (b4),
        .bin         (bin4),
        .diff        (diff4),
        .bout        (bout4),
        .done_valid  (dv4),
        .done_ready  (dr4),
        .busy        (busy4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for start_ready, present operands, return just after the accepting edge.
    task automatic launch8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin, input string tag);
        int n;
        n = 0;
        while (start_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " start_ready"}, 32'(start_ready), 32'd1);
        a           = ta;
        b           = tb;
        bin         = tbin;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    // From just after the accepting edge: done_valid must stay low for 7 edges,
    // then be high after the 8th with the expected result.
    task automatic finish8(input logic [7:0] ed, input logic eb, input string tag);
        logic early;
        early = 1'b0;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            if (done_valid !== 1'b0) early = 1'b1;
        end
        check({tag, " no early done"}, 32'(early), 32'd0);
        @(negedge clk);
        check({tag, " done_valid"}, 32'(done_valid), 32'd1);
        check({tag, " diff"}, 32'(diff), 32'(ed));
        check({tag, " bout"}, 32'(bout), 32'(eb));
    endtask

    task automatic release8(input string tag);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        check({tag, " idle done_valid"}, 32'(done_valid), 32'd0);
        check({tag, " idle start_ready"}, 32'(start_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] hold_d;
        logic       hold_b;
        logic       seen;
        int         r;
        logic [4:0] exp4;

        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        start_valid = 1'b0;
        done_ready  = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        sv4 = 1'b0; dr4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;

        // ---- reset state ----
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst start_ready", 32'(start_ready), 32'd0);
        check("rst done_valid", 32'(done_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst diff", 32'(diff), 32'd0);
        check("rst bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst start_ready", 32'(start_ready), 32'd1);

        // ---- 5 - 3 - 0 (accept on first edge after reset) ----
        launch8(8'd5, 8'd3, 1'b0, "5-3");
        check("5-3 busy in shift", 32'(busy), 32'd1);
        check("5-3 start_ready in shift", 32'(start_ready), 32'd0);
        finish8(8'd2, 1'b0, "5-3");
        release8("5-3");

        // ---- borrow / wrap cases ----
        launch8(8'd3, 8'd5, 1'b0, "3-5");
        finish8(8'd254, 1'b1, "3-5");
        release8("3-5");

        launch8(8'd0, 8'd0, 1'b1, "0-0-1");
        finish8(8'd255, 1'b1, "0-0-1");
        release8("0-0-1");

        launch8(8'd255, 8'd255, 1'b0, "255-255");
        finish8(8'd0, 1'b0, "255-255");
        release8("255-255");

        // ---- hold in DONE for 5 cycles: 200 - 57 - 1 = 142 ----
        launch8(8'd200, 8'd57, 1'b1, "hold");
        finish8(8'd142, 1'b0, "hold");
        hold_d = 8'd142;
        hold_b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold done_valid", 32'(done_valid), 32'd1);
            check("hold diff", 32'(diff), 32'(hold_d));
            check("hold bout", 32'(bout), 32'(hold_b));
            check("hold start_ready", 32'(start_ready), 32'd0);
        end
        release8("hold");

        // ---- new start during SHIFT is ignored: 100 - 37 - 1 = 62 ----
        launch8(8'd100, 8'd37, 1'b1, "ignore");
        a           = 8'd1;
        b           = 8'd200;
        bin         = 1'b0;
        start_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a           = 8'd77;
        b           = 8'd9;
        start_valid = 1'b0;
        // Two of the eight edges already elapsed above.
        for (int k = 2; k < 7; k++) begin
            @(negedge clk);
        end
        check("ignore not yet done", 32'(done_valid), 32'd0);
        @(negedge clk);
        check("ignore done_valid", 32'(done_valid), 32'd1);
        check("ignore diff", 32'(diff), 32'd62);
        check("ignore bout", 32'(bout), 32'd0);
        release8("ignore");
        @(negedge clk);
        check("retain diff in idle", 32'(diff), 32'd62);
        check("retain busy in idle", 32'(busy), 32'd0);

        // ---- reset at bit 4 of SHIFT aborts the operation ----
        launch8(8'd200, 8'd100, 1'b0, "abort");
        repeat (4) @(negedge clk);
        check("abort busy before rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort diff", 32'(diff), 32'd0);
        check("abort bout", 32'(bout), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done_valid", 32'(done_valid), 32'd0);
        check("abort start_ready", 32'(start_ready), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done_valid !== 1'b0) seen = 1'b1;
        end
        check("abort no done pulse", 32'(seen), 32'd0);

        launch8(8'd10, 8'd7, 1'b0, "10-7");
        finish8(8'd3, 1'b0, "10-7");
        release8("10-7");

        // ---- exhaustive sweep on the 4-bit instance ----
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    r    = ia - ib - ic;
                    exp4 = {(r < 0) ? 1'b1 : 1'b0, 4'(r)};
                    a4   = 4'(ia);
                    b4   = 4'(ib);
                    bin4 = ic[0];
                    sv4  = 1'b1;
                    @(negedge clk);
                    sv4  = 1'b0;
                    seen = 1'b0;
                    for (int k = 1; k < 4; k++) begin
                        @(negedge clk);
                        if (dv4 !== 1'b0) seen = 1'b1;
                    end
                    @(negedge clk);
                    check($sformatf("w4 %0d-%0d-%0d latency", ia, ib, ic),
                          32'({seen, dv4}), 32'b01);
                    check($sformatf("w4 %0d-%0d-%0d result", ia, ib, ic),
                          32'({bout4, diff4}), 32'(exp4));
                    dr4 = 1'b1;
                    @(negedge clk);
                    dr4 = 1'b0;
                end
            end
        end
        check("w4 ready after sweep", 32'(sr4), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start_valid  input  1  operands present on a/b/bin.
REQ-005 SHALL have port: start_ready  output  1  block can accept operands.
REQ-006 SHALL have port: a  input  WIDTH  minuend.
REQ-007 SHALL have port: b  input  WIDTH  subtrahend.
REQ-008 SHALL have port: bin  input  1  borrow-in.
REQ-009 SHALL have port: diff  output  WIDTH  registered difference.
REQ-010 SHALL have port: bout  output  1  registered borrow-out.
REQ-011 SHALL have port: done_valid  output  1  diff/bout valid.
REQ-012 SHALL have port: done_ready  input  1  consumer accepts result.
REQ-013 SHALL have port: busy  output  1  high in SHIFT or DONE.

Function
REQ-014 SHALL compute {bout,diff} = a - b - bin, i.e. bout=1 iff a < b+bin (unsigned), diff = (a-b-bin) mod 2^WIDTH.
REQ-015 SHALL process one bit per clock, LSB first, via a one-bit full-subtractor cell: d = x^y^br, br_next = (~x&y) | (~(x^y)&br).
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-017 IDLE: start_ready=1; on an edge with start_valid=1, latch a, b, bin into shift/borrow registers, clear bit counter, go to SHIFT.
REQ-018 SHIFT: each edge shifts one result bit in and increments counter; on the edge processing bit WIDTH-1, load diff/bout and go to DONE.
REQ-019 Latency: done_valid SHALL rise exactly WIDTH edges after the accepting edge.
REQ-020 DONE: done_valid=1, diff/bout held stable; on edge with done_ready=1 go to IDLE; with done_ready=0 stay indefinitely.
REQ-021 start_ready SHALL be 0 in SHIFT and DONE; start_valid and a/b/bin changes there SHALL be ignored.
REQ-022 No result/start overlap: a new start is accepted at earliest the edge after the DONE->IDLE edge.
REQ-023 diff/bout SHALL retain the last result after return to IDLE until the next completion.
REQ-024 Bit counter SHALL be $clog2(WIDTH) bits wide and SHALL not wrap within an operation.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, diff=0, bout=0, done_valid=0, busy=0, counter=0, start_ready=1 while deasserted... start_ready SHALL be 0 while rst=1.
REQ-026 Reset mid-SHIFT or in DONE SHALL abort the operation with no done_valid pulse afterward.
REQ-027 First acceptance after reset SHALL be possible on the first edge with rst=0.

Structure
REQ-028 Shared package serial_sub_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and default WIDTH constant.
REQ-029 SHALL instantiate one sub-module full_subtractor (ports x, y, bin, d, bout), purely combinational, mirroring the team's full adder.
REQ-030 State, counter, operand shift registers and borrow flop SHALL be in one always_ff with async reset.

Verification
REQ-031 a=5, b=3, bin=0 -> after 8 edges done_valid=1, diff=2, bout=0.
REQ-032 a=3, b=5, bin=0 -> diff=254, bout=1; a=0, b=0, bin=1 -> diff=255, bout=1; a=255, b=255, bin=0 -> diff=0, bout=0.
REQ-033 done_ready held 0 for 5 cycles in DONE -> done_valid, diff, bout stable; release -> IDLE next edge, start_ready=1.
REQ-034 start_valid=1 with new operands during SHIFT -> ignored; result matches original operands.
REQ-035 rst pulsed at bit 4 of SHIFT -> outputs 0 at once, no done_valid; subsequent 10-7 -> diff=3, bout=0.
REQ-036 Exhaustive sweep with WIDTH=4, all a, b, bin -> every result matches the reference model a-b-bin.
